spi_tx_drain: RTL and testbench

//  - SPI master transmit engine: drains the APB-filled TX FIFO, serialises each word onto SCLK/MOSI under CS_n.
//  - Sits between the TX FIFO read port and the SPI pins; the consumer end of the PSEL-driven write count.
//  - Decrement side: reports words sent so software reconciles against words written.

---
 rtl/spi_tx_drain.sv | 127 ++++++++++++
 tb/tb_spi_tx_drain.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_drain.sv
// spi_tx_drain: SPI mode-0 master that drains a FWFT TX FIFO; define SPI_TX_LSB_FIRST_EN for LSB-first shifting
module spi_tx_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1),
  parameter int CLK_DIV    = 4
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  enable,
  input  logic [CNT_W-1:0]      fifo_cnt,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_pop,
  output logic                  SCLK,
  output logic                  MOSI,
  output logic                  CS_n,
  output logic                  busy,
  output logic                  tx_done,
  output logic [CNT_W-1:0]      words_sent
);
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_e;
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d, shifted;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d, done_q, done_d;
  logic [CNT_W-1:0]      words_q, words_d;
  logic                  can_pop, tick, head_bit, next_bit;
`ifdef SPI_TX_LSB_FIRST_EN
  assign shifted  = sr_q >> 1;
  assign head_bit = sr_q[0];
  assign next_bit = shifted[0];
`else
  assign shifted  = sr_q << 1;
  assign head_bit = sr_q[DATA_WIDTH-1];
  assign next_bit = shifted[DATA_WIDTH-1];
`endif
  assign can_pop    = PRESETn && enable && fifo_cnt != '0;
  assign tick       = div_q == DIV_LAST;
  assign SCLK       = sclk_q;
  assign MOSI       = mosi_q;
  assign CS_n       = cs_n_q;
  assign tx_done    = done_q;
  assign words_sent = words_q;
  assign busy       = state_q != IDLE;
  // next-state: pop/load, SCLK generation, shifting on falling edges, end-of-frame gap
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    cs_n_d   = cs_n_q;
    done_d   = 1'b0;
    words_d  = words_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: if (can_pop) begin
        fifo_pop = 1'b1;
        sr_d     = fifo_rdata;
        cs_n_d   = 1'b0;
        state_d  = LOAD;
      end
      LOAD: begin
        mosi_d  = head_bit;
        div_d   = '0;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            sr_d   = shifted;
            mosi_d = next_bit;
            bit_d  = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              words_d  = words_q + 1'b1;
              fifo_pop = can_pop;
              sr_d     = can_pop ? fifo_rdata : shifted;
              state_d  = can_pop ? LOAD : GAP;
            end
          end
        end
      end
      GAP: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and pin registers; reset aborts any transfer immediately
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      sr_q    <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
      words_q <= words_d;
    end
  end
endmodule

// File: tb/tb_spi_tx_drain.sv
// tb_spi_tx_drain: directed/random bench for spi_tx_drain with a queue-based FIFO and bit-stream model
module tb_spi_tx_drain;
  localparam int DW = 8;
  localparam int CD = 4;
  localparam int CW = 4;
  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          enable = 1'b0;
  logic [CW-1:0] fifo_cnt = '0;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_pop, SCLK, MOSI, CS_n, busy, tx_done;
  logic [CW-1:0] words_sent;
  always #5 PCLK = ~PCLK;
  spi_tx_drain #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .CLK_DIV(CD)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .enable(enable), .fifo_cnt(fifo_cnt),
    .fifo_rdata(fifo_rdata), .fifo_pop(fifo_pop), .SCLK(SCLK), .MOSI(MOSI),
    .CS_n(CS_n), .busy(busy), .tx_done(tx_done), .words_sent(words_sent)
  );
  logic [DW-1:0] fifo_q[$];
  logic          rise_bits[$];
  int errors = 0, checks = 0, cycle = 0, bad_pops = 0;
  int pops, dones, rises, cs_rises, rise_cs_high;
  int cs_fall_cyc, first_rise_cyc, last_fall_cyc, cs_rise_cyc, done_cyc;
  logic prev_sclk = 1'b0, prev_cs = 1'b1, pend;
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic clear();
    pops = 0; dones = 0; rises = 0; cs_rises = 0; rise_cs_high = 0;
    cs_fall_cyc = -1; first_rise_cyc = -1; last_fall_cyc = -1; cs_rise_cyc = -1; done_cyc = -1;
    rise_bits.delete();
  endtask
  task automatic refresh();
    fifo_cnt   = CW'(fifo_q.size());
    fifo_rdata = fifo_q.size() != 0 ? fifo_q[0] : '0;
  endtask
  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask
  task automatic step();
    #1;
    pend = fifo_pop;
    if (fifo_pop && fifo_cnt == 0) bad_pops++;
    @(posedge PCLK);
    #1;
    cycle++;
    if (pend && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    refresh();
    #1;
    if (SCLK && !prev_sclk) begin
      rises++;
      rise_bits.push_back(MOSI);
      if (CS_n) rise_cs_high++;
      if (first_rise_cyc < 0) first_rise_cyc = cycle;
    end
    if (!SCLK && prev_sclk) last_fall_cyc = cycle;
    if (!CS_n && prev_cs) cs_fall_cyc = cycle;
    if (CS_n && !prev_cs) begin
      cs_rises++;
      cs_rise_cyc = cycle;
    end
    if (tx_done) begin
      dones++;
      done_cyc = cycle;
    end
    prev_sclk = SCLK;
    prev_cs   = CS_n;
  endtask
  task automatic run_idle(input string tag, input int maxc);
    int n;
    n = 0;
    repeat (2) step();
    while (busy && n < maxc) begin
      step();
      n++;
    end
    check({tag, "_idle_busy"}, busy, 0);
  endtask
  task automatic wait_rises(input string tag, input int target, input int maxc);
    int n;
    n = 0;
    while (rises < target && n < maxc) begin
      step();
      n++;
    end
    check({tag, "_rises"}, rises, target);
  endtask
  task automatic check_words(input string tag, input logic [DW-1:0] exp_w[$]);
    check({tag, "_nbits"}, rise_bits.size(), exp_w.size() * DW);
    for (int i = 0; i < exp_w.size() && (i + 1) * DW <= rise_bits.size(); i++) begin
      logic [DW-1:0] w;
      w = '0;
      for (int b = 0; b < DW; b++) begin
`ifdef SPI_TX_LSB_FIRST_EN
        w[b] = rise_bits[i*DW+b];
`else
        w[DW-1-b] = rise_bits[i*DW+b];
`endif
      end
      check({tag, "_word"}, w, exp_w[i]);
    end
  endtask
  initial begin
    logic [DW-1:0] exp_w[$];
    logic [DW-1:0] w0, w1;
    int ws_exp;
    ws_exp = 0;
    clear();
    push(8'h01); push(8'h80); push(8'hFF);
    enable = 1'b1;
    repeat (6) step();
    check("rst_pops", pops, 0);
    check("rst_csn", CS_n, 1);
    check("rst_sclk", SCLK, 0);
    check("rst_mosi", MOSI, 0);
    check("rst_busy", busy, 0);
    check("rst_words", words_sent, 0);
    check("rst_fifo", fifo_q.size(), 3);
    PRESETn = 1'b1;
    clear();
    run_idle("burst3", 2000);
    exp_w = {8'h01, 8'h80, 8'hFF};
    check_words("burst3", exp_w);
    ws_exp = (ws_exp + 3) % 16;
    check("burst3_pops", pops, 3);
    check("burst3_rises", rises, 24);
    check("burst3_dones", dones, 1);
    check("burst3_cs_rises", cs_rises, 1);
    check("burst3_rise_cs_high", rise_cs_high, 0);
    check("burst3_words", words_sent, ws_exp);
    clear();
    push(8'hA5);
    run_idle("a5", 2000);
    exp_w = {8'hA5};
    check_words("a5", exp_w);
    ws_exp = (ws_exp + 1) % 16;
    check("a5_pops", pops, 1);
    check("a5_dones", dones, 1);
    check("a5_gap", cs_rise_cyc - last_fall_cyc, CD);
    check("a5_done_at_cs_rise", done_cyc, cs_rise_cyc);
    check("a5_cs_lead", int'(first_rise_cyc - cs_fall_cyc >= CD), 1);
    check("a5_csn_idle", CS_n, 1);
    check("a5_words", words_sent, ws_exp);
    for (int t = 0; t < 3; t++) begin
      clear();
      w0 = DW'($urandom);
      push(w0);
      run_idle("rnd1", 2000);
      exp_w = {w0};
      check_words("rnd1", exp_w);
      ws_exp = (ws_exp + 1) % 16;
      check("rnd1_words", words_sent, ws_exp);
    end
    clear();
    w0 = DW'($urandom);
    w1 = DW'($urandom);
    push(w0); push(w1);
    wait_rises("en_drop", 4, 500);
    enable = 1'b0;
    run_idle("en_drop", 2000);
    exp_w = {w0};
    check_words("en_drop", exp_w);
    ws_exp = (ws_exp + 1) % 16;
    check("en_drop_pops", pops, 1);
    check("en_drop_dones", dones, 1);
    check("en_drop_fifo", fifo_q.size(), 1);
    check("en_drop_words", words_sent, ws_exp);
    repeat (20) step();
    check("en_off_pops", pops, 1);
    check("en_off_busy", busy, 0);
    fifo_q.delete();
    refresh();
    enable = 1'b1;
    clear();
    w0 = DW'($urandom);
    w1 = DW'($urandom);
    push(w0); push(w1);
    wait_rises("abort", 3, 500);
    PRESETn = 1'b0;
    #1;
    check("abort_csn", CS_n, 1);
    check("abort_sclk", SCLK, 0);
    check("abort_busy", busy, 0);
    check("abort_words", words_sent, 0);
    repeat (3) step();
    check("abort_pops", pops, 1);
    check("abort_dones", dones, 0);
    check("abort_fifo", fifo_q.size(), 1);
    PRESETn = 1'b1;
    clear();
    run_idle("restart", 2000);
    exp_w = {w1};
    check_words("restart", exp_w);
    ws_exp = 1;
    check("restart_pops", pops, 1);
    check("restart_dones", dones, 1);
    check("restart_words", words_sent, ws_exp);
    for (int bt = 0; bt < 2; bt++) begin
      clear();
      exp_w.delete();
      for (int i = 0; i < 8; i++) begin
        w0 = DW'($urandom);
        push(w0);
        exp_w.push_back(w0);
      end
      run_idle("batch8", 2000);
      check_words("batch8", exp_w);
      ws_exp = (ws_exp + 8) % 16;
      check("batch8_pops", pops, 8);
      check("batch8_rises", rises, 64);
      check("batch8_dones", dones, 1);
      check("batch8_cs_rises", cs_rises, 1);
      check("batch8_words", words_sent, ws_exp);
    end
    check("pop_when_empty", bad_pops, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
